pwm_capture: RTL

Measures an incoming PWM waveform (asynchronous to `clk`) and reports its period, high time and a 4-step brightness level. It is the receiving end of the breathing-LED PWM generator. It decodes a PWM stream, external or looped back from the generator, into duty information that can drive four LEDs as a bar display or feed a self-check.

---
 rtl/pwm_pkg.sv | 18 +
 rtl/sync_edge.sv | 33 +++
 rtl/pwm_capture.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block and its companion PWM generator.
package pwm_pkg;

  // Measurement FSM: waiting for a first edge, inside the high phase, inside the low phase
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pwm_state_t;

  // Number of thermometer steps on the LED bar
  localparam int LED_LVLS = 4;

  // Default counter width and dead-input timeout, shared with the generator
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 50000;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous input, followed by a delay stage
// so that single-cycle rise/fall strobes can be derived in the clk domain.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  // Synchroniser chain plus delay register; all stages clear on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input in clk cycles
// and turns the duty ratio into a 4-step thermometer code for an LED bar.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pwm_in,
  output logic [CNT_W-1:0]    period,
  output logic [CNT_W-1:0]    high_time,
  output logic [LED_LVLS-1:0] led_level,
  output logic                meas_valid,
  output logic                no_signal
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic level;
  logic rise;
  logic fall;

  pwm_state_t state;
  pwm_state_t state_nxt;

  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [CNT_W-1:0]    hi_lat;
  logic [CNT_W-1:0]    hi_lat_nxt;
  logic [CNT_W-1:0]    period_nxt;
  logic [CNT_W-1:0]    high_time_nxt;
  logic [LED_LVLS-1:0] led_nxt;
  logic                meas_valid_nxt;
  logic                no_signal_nxt;

  // Products for the duty comparison, widened by two bits so 4x never overflows
  logic [CNT_W+1:0] hi_x4;
  logic [CNT_W+1:0] per_x1;
  logic [CNT_W+1:0] per_x2;
  logic [CNT_W+1:0] per_x3;
  logic [CNT_W+1:0] per_x4;
  logic [LED_LVLS-1:0] duty_level;

  sync_edge u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (pwm_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  // Duty thermometer for the measurement that closes this cycle: the new period
  // is the running count and the high time is the latched high count
  always_comb begin
    hi_x4  = {hi_lat, 2'b00};
    per_x1 = {2'b00, cnt};
    per_x2 = {1'b0, cnt, 1'b0};
    per_x3 = per_x2 + per_x1;
    per_x4 = {cnt, 2'b00};
    duty_level    = '0;
    duty_level[0] = (hi_x4 >= per_x1);
    duty_level[1] = (hi_x4 >= per_x2);
    duty_level[2] = (hi_x4 >= per_x3);
    duty_level[3] = (hi_x4 >= per_x4);
  end

  // Next-state and next-output logic: count through high and low phases,
  // publish a measurement on each closing rise, give up after TIMEOUT cycles
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    hi_lat_nxt     = hi_lat;
    period_nxt     = period;
    high_time_nxt  = high_time;
    led_nxt        = led_level;
    meas_valid_nxt = 1'b0;
    no_signal_nxt  = no_signal;

    case (state)
      ST_IDLE: begin
        if (rise) begin
          cnt_nxt   = CNT_ONE;
          state_nxt = ST_HIGH;
        end
      end

      ST_HIGH: begin
        cnt_nxt = cnt + CNT_ONE;
        if (fall) begin
          hi_lat_nxt = cnt;
          state_nxt  = ST_LOW;
        end else if (cnt == TIMEOUT_CNT) begin
          cnt_nxt       = '0;
          state_nxt     = ST_IDLE;
          no_signal_nxt = 1'b1;
          led_nxt       = {LED_LVLS{level}};
        end
      end

      ST_LOW: begin
        cnt_nxt = cnt + CNT_ONE;
        if (rise) begin
          period_nxt     = cnt;
          high_time_nxt  = hi_lat;
          led_nxt        = duty_level;
          meas_valid_nxt = 1'b1;
          no_signal_nxt  = 1'b0;
          cnt_nxt        = CNT_ONE;
          state_nxt      = ST_HIGH;
        end else if (cnt == TIMEOUT_CNT) begin
          cnt_nxt       = '0;
          state_nxt     = ST_IDLE;
          no_signal_nxt = 1'b1;
          led_nxt       = {LED_LVLS{level}};
        end
      end

      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset drops any measurement in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      hi_lat     <= '0;
      period     <= '0;
      high_time  <= '0;
      led_level  <= '0;
      meas_valid <= 1'b0;
      no_signal  <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      hi_lat     <= hi_lat_nxt;
      period     <= period_nxt;
      high_time  <= high_time_nxt;
      led_level  <= led_nxt;
      meas_valid <= meas_valid_nxt;
      no_signal  <= no_signal_nxt;
    end
  end

endmodule
